cpu_trace_buffer: RTL and testbench

- Synthesizable, parametrised event tracer for the multi-cycle CPU core.
- Watches the core's fetch, memory and register-write strobes each cycle and stores one timestamped record per cycle in an on-chip FIFO.
- Records drain through a valid/ready port, replacing testbench-only monitoring.
- Adds what a passive monitor lacks: a per-type event mask, PC-match trigger, stop-on-full or wrap (overwrite oldest) modes, and a saturating drop counter.

---
 rtl/cpu_trace_buffer.sv | 179 +++++++++++++++++
 tb/tb_cpu_trace_buffer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_buffer.sv
// Event tracer for the multi-cycle core: captures one prioritised,
// timestamped record per cycle into a first-word-fall-through FIFO.
module cpu_trace_buffer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16,
  parameter int RA_W   = 5,
  localparam int PW    = $clog2(DEPTH),
  localparam int LW    = PW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_enable,
  input  logic              cfg_wrap,
  input  logic              cfg_trig_en,
  input  logic [ADDR_W-1:0] cfg_trig_pc,
  input  logic [3:0]        cfg_mask,
  input  logic [ADDR_W-1:0] pc_current,
  input  logic              ir_write,
  input  logic [DATA_W-1:0] instruction,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] memory_address,
  input  logic [DATA_W-1:0] memory_data_out,
  input  logic [DATA_W-1:0] b_reg_out,
  input  logic              reg_write,
  input  logic [RA_W-1:0]   reg_write_addr,
  input  logic [DATA_W-1:0] reg_write_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_type,
  output logic [TS_W-1:0]   out_ts,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic [LW-1:0]     level,
  output logic [15:0]       overflow_cnt,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    STOPPED = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [LW-1:0]     lvl_q, lvl_d;
  logic [15:0]       ovf_q, ovf_d;
  logic [TS_W-1:0]   ts_q;

  logic [1:0]        typ_m  [DEPTH];
  logic [TS_W-1:0]   ts_m   [DEPTH];
  logic [ADDR_W-1:0] pc_m   [DEPTH];
  logic [ADDR_W-1:0] addr_m [DEPTH];
  logic [DATA_W-1:0] data_m [DEPTH];

  logic              q_f, q_mr, q_mw, q_rw;
  logic [2:0]        n_ev, inc;
  logic              match, capt, push_try, full, pop;
  logic              push_ok, ovw, stop;
  logic [1:0]        w_typ;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic [16:0]       ovf_sum;

  assign q_f   = ir_write  & cfg_mask[0];
  assign q_mr  = mem_read  & cfg_mask[1];
  assign q_mw  = mem_write & cfg_mask[2];
  assign q_rw  = reg_write & cfg_mask[3] & (reg_write_addr != '0);
  assign n_ev  = {2'b0, q_f} + {2'b0, q_mr} + {2'b0, q_mw} + {2'b0, q_rw};

  assign match = pc_current == cfg_trig_pc;
  assign capt  = cfg_enable &&
                 (state_q == CAPTURE || (state_q == ARMED && match));
  assign push_try = capt && (n_ev != 3'd0);
  assign full  = lvl_q == LW'(DEPTH);
  assign pop   = out_valid && out_ready;
  assign push_ok = push_try && (!full || pop || cfg_wrap);
  assign ovw   = push_try && full && !pop && cfg_wrap;
  assign stop  = push_try && full && !pop && !cfg_wrap;

  always_comb begin
    w_typ  = 2'd0;
    w_addr = '0;
    w_data = instruction;
    if (q_mw) begin
      w_typ  = 2'd2;
      w_addr = memory_address;
      w_data = b_reg_out;
    end else if (q_mr) begin
      w_typ  = 2'd1;
      w_addr = memory_address;
      w_data = memory_data_out;
    end else if (q_rw) begin
      w_typ  = 2'd3;
      w_addr = {{(ADDR_W-RA_W){1'b0}}, reg_write_addr};
      w_data = reg_write_data;
    end
  end

  // Losers of the priority pick, the winner itself when it cannot be
  // stored, and everything seen while stopped all count as drops.
  always_comb begin
    inc = 3'd0;
    if (push_try)
      inc = n_ev - 3'd1 + {2'b0, ovw | stop};
    else if (cfg_enable && state_q == STOPPED)
      inc = n_ev;
    ovf_sum = {1'b0, ovf_q} + {14'b0, inc};
    ovf_d   = ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
  end

  always_comb begin
    rd_d  = rd_q + {{(PW-1){1'b0}}, pop | ovw};
    wr_d  = wr_q + {{(PW-1){1'b0}}, push_ok};
    lvl_d = lvl_q;
    if (push_ok && !pop && !ovw)
      lvl_d = lvl_q + LW'(1);
    else if (pop && !push_ok)
      lvl_d = lvl_q - LW'(1);
  end

  always_comb begin
    state_d = state_q;
    if (!cfg_enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = cfg_trig_en ? ARMED : CAPTURE;
        ARMED:   state_d = match ? CAPTURE : ARMED;
        CAPTURE: state_d = stop ? STOPPED : CAPTURE;
        default: state_d = STOPPED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      rd_q    <= '0;
      wr_q    <= '0;
      lvl_q   <= '0;
      ovf_q   <= '0;
      ts_q    <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      lvl_q   <= lvl_d;
      ovf_q   <= ovf_d;
      ts_q    <= ts_q + TS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push_ok) begin
      typ_m[wr_q]  <= w_typ;
      ts_m[wr_q]   <= ts_q;
      pc_m[wr_q]   <= pc_current;
      addr_m[wr_q] <= w_addr;
      data_m[wr_q] <= w_data;
    end
  end

  assign out_valid    = lvl_q != '0;
  assign out_type     = out_valid ? typ_m[rd_q]  : '0;
  assign out_ts       = out_valid ? ts_m[rd_q]   : '0;
  assign out_pc       = out_valid ? pc_m[rd_q]   : '0;
  assign out_addr     = out_valid ? addr_m[rd_q] : '0;
  assign out_data     = out_valid ? data_m[rd_q] : '0;
  assign level        = lvl_q;
  assign overflow_cnt = ovf_q;
  assign state        = state_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer (DEPTH=4).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_cpu_trace_buffer;

  logic        clk = 0;
  logic        reset;
  logic        cfg_enable, cfg_wrap, cfg_trig_en;
  logic [31:0] cfg_trig_pc;
  logic [3:0]  cfg_mask;
  logic [31:0] pc_current;
  logic        ir_write;
  logic [31:0] instruction;
  logic        mem_read, mem_write;
  logic [31:0] memory_address, memory_data_out, b_reg_out;
  logic        reg_write;
  logic [4:0]  reg_write_addr;
  logic [31:0] reg_write_data;
  logic        out_valid, out_ready;
  logic [1:0]  out_type;
  logic [15:0] out_ts;
  logic [31:0] out_pc, out_addr, out_data;
  logic [2:0]  level;
  logic [15:0] overflow_cnt;
  logic [1:0]  state;

  int errors = 0;
  int checks = 0;

  cpu_trace_buffer #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .cfg_enable(cfg_enable), .cfg_wrap(cfg_wrap),
    .cfg_trig_en(cfg_trig_en), .cfg_trig_pc(cfg_trig_pc),
    .cfg_mask(cfg_mask), .pc_current(pc_current),
    .ir_write(ir_write), .instruction(instruction),
    .mem_read(mem_read), .mem_write(mem_write),
    .memory_address(memory_address),
    .memory_data_out(memory_data_out), .b_reg_out(b_reg_out),
    .reg_write(reg_write), .reg_write_addr(reg_write_addr),
    .reg_write_data(reg_write_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_type(out_type), .out_ts(out_ts), .out_pc(out_pc),
    .out_addr(out_addr), .out_data(out_data),
    .level(level), .overflow_cnt(overflow_cnt), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ir_write = 0; mem_read = 0; mem_write = 0; reg_write = 0;
    instruction = 0; memory_address = 0; memory_data_out = 0;
    b_reg_out = 0; reg_write_addr = 0; reg_write_data = 0;
    out_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    cfg_enable = 0; cfg_wrap = 0; cfg_trig_en = 0;
    cfg_trig_pc = 0; cfg_mask = 4'hF; pc_current = 0;
    reset = 0;
    tick();
    reset = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    cfg_enable = 1; cfg_wrap = 0; cfg_trig_en = 0;
    cfg_trig_pc = 0; cfg_mask = 4'hF; pc_current = 32'h40;
    ir_write = 1; mem_write = 1; reg_write = 1; reg_write_addr = 3;
    reset = 0;
    tick(); tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++;
      $display("FAIL rst_valid got %0b want 0", out_valid); end
    checks++;
    if (level !== 3'd0) begin errors++;
      $display("FAIL rst_level got %0d want 0", level); end
    checks++;
    if (overflow_cnt !== 16'd0) begin errors++;
      $display("FAIL rst_ovf got %0d want 0", overflow_cnt); end
    checks++;
    if (state !== 2'd0) begin errors++;
      $display("FAIL rst_state got %0d want 0", state); end
    checks++;
    if (out_data !== 32'd0) begin errors++;
      $display("FAIL rst_data got %h want 0", out_data); end
    cfg_enable = 0;
    reset = 1;
    tick(); tick(); tick();
    checks++;
    if (level !== 3'd0) begin errors++;
      $display("FAIL dis_level got %0d want 0", level); end
    checks++;
    if (state !== 2'd0) begin errors++;
      $display("FAIL dis_state got %0d want 0", state); end
  endtask

  task automatic test_basic();
    logic [15:0] ts0;
    do_reset();
    cfg_enable = 1;
    tick();
    checks++;
    if (state !== 2'd2) begin errors++;
      $display("FAIL cap_state got %0d want 2", state); end
    ir_write = 1; instruction = 32'h00500093; pc_current = 0;
    tick();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b1) begin errors++;
      $display("FAIL f_valid got %0b want 1", out_valid); end
    checks++;
    if ({out_type, out_addr, out_data} !== {2'd0, 32'd0, 32'h00500093}) begin
      errors++;
      $display("FAIL f_rec got t=%0d a=%h d=%h want t=0 a=0 d=00500093",
               out_type, out_addr, out_data); end
    ts0 = out_ts;
    tick(); tick();
    reg_write = 1; reg_write_addr = 1; reg_write_data = 5;
    pc_current = 32'h4;
    tick();
    idle_inputs();
    checks++;
    if (level !== 3'd2) begin errors++;
      $display("FAIL b_level got %0d want 2", level); end
    out_ready = 1;
    tick();
    out_ready = 0;
    checks++;
    if ({out_type, out_addr, out_data, out_pc} !==
        {2'd3, 32'h1, 32'h5, 32'h4}) begin errors++;
      $display("FAIL rw_rec got t=%0d a=%h d=%h pc=%h want t=3 a=1 d=5 pc=4",
               out_type, out_addr, out_data, out_pc); end
    checks++;
    if (out_ts - ts0 !== 16'd3) begin errors++;
      $display("FAIL ts_gap got %0d want 3", out_ts - ts0); end
    out_ready = 1;
    tick();
    out_ready = 0;
    checks++;
    if (level !== 3'd0) begin errors++;
      $display("FAIL b_drain got %0d want 0", level); end
  endtask

  task automatic test_priority();
    do_reset();
    cfg_enable = 1;
    tick();
    mem_write = 1; memory_address = 32'h10; b_reg_out = 32'hAA;
    reg_write = 1; reg_write_addr = 2; reg_write_data = 32'h77;
    pc_current = 32'h20;
    tick();
    idle_inputs();
    checks++;
    if (level !== 3'd1) begin errors++;
      $display("FAIL p_level got %0d want 1", level); end
    checks++;
    if ({out_type, out_addr, out_data} !== {2'd2, 32'h10, 32'hAA}) begin
      errors++;
      $display("FAIL p_rec got t=%0d a=%h d=%h want t=2 a=10 d=aa",
               out_type, out_addr, out_data); end
    checks++;
    if (overflow_cnt !== 16'd1) begin errors++;
      $display("FAIL p_ovf got %0d want 1", overflow_cnt); end
    out_ready = 1;
    tick();
    out_ready = 0;
    reg_write = 1; reg_write_addr = 0; reg_write_data = 32'h9;
    tick();
    idle_inputs();
    checks++;
    if (level !== 3'd0) begin errors++;
      $display("FAIL x0_level got %0d want 0", level); end
    checks++;
    if (overflow_cnt !== 16'd1) begin errors++;
      $display("FAIL x0_ovf got %0d want 1", overflow_cnt); end
  endtask

  task automatic test_trigger();
    do_reset();
    cfg_enable = 1; cfg_trig_en = 1; cfg_trig_pc = 32'h8;
    tick();
    checks++;
    if (state !== 2'd1) begin errors++;
      $display("FAIL t_armed got %0d want 1", state); end
    ir_write = 1; instruction = 32'h11; pc_current = 0;
    tick();
    instruction = 32'h22; pc_current = 32'h4;
    tick();
    checks++;
    if ({level, state} !== {3'd0, 2'd1}) begin errors++;
      $display("FAIL t_wait got lvl=%0d st=%0d want lvl=0 st=1",
               level, state); end
    instruction = 32'h33; pc_current = 32'h8;
    tick();
    idle_inputs();
    checks++;
    if ({level, state} !== {3'd1, 2'd2}) begin errors++;
      $display("FAIL t_hit got lvl=%0d st=%0d want lvl=1 st=2",
               level, state); end
    checks++;
    if ({out_pc, out_data} !== {32'h8, 32'h33}) begin errors++;
      $display("FAIL t_rec got pc=%h d=%h want pc=8 d=33",
               out_pc, out_data); end
  endtask

  task automatic test_full(input logic wrap);
    do_reset();
    cfg_enable = 1; cfg_wrap = wrap;
    tick();
    for (int i = 0; i < 6; i++) begin
      mem_read = 1; memory_address = i;
      memory_data_out = 32'h100 + i;
      tick();
    end
    idle_inputs();
    checks++;
    if (level !== 3'd4) begin errors++;
      $display("FAIL full%0d_level got %0d want 4", wrap, level); end
    checks++;
    if (state !== (wrap ? 2'd2 : 2'd3)) begin errors++;
      $display("FAIL full%0d_state got %0d want %0d", wrap, state,
               wrap ? 2 : 3); end
    checks++;
    if (overflow_cnt !== 16'd2) begin errors++;
      $display("FAIL full%0d_ovf got %0d want 2", wrap, overflow_cnt); end
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_data !== 32'h100 + (wrap ? i + 2 : i)) begin errors++;
        $display("FAIL full%0d_drain%0d got %h want %h", wrap, i,
                 out_data, 32'h100 + (wrap ? i + 2 : i)); end
      tick();
    end
    out_ready = 0;
    checks++;
    if (out_valid !== 1'b0) begin errors++;
      $display("FAIL full%0d_empty got %0b want 0", wrap, out_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cfg_enable = 1;
    tick();
    for (int i = 0; i < 7; i++) begin
      if (i == 4) out_ready = 1;
      mem_write = 1; memory_address = 32'h200 + i; b_reg_out = 32'h50 + i;
      tick();
      if (i >= 4) begin
        checks++;
        if ({level, overflow_cnt, state} !== {3'd4, 16'd0, 2'd2}) begin
          errors++;
          $display("FAIL b2b%0d got lvl=%0d ovf=%0d st=%0d want 4 0 2",
                   i, level, overflow_cnt, state); end
        checks++;
        if (out_data !== 32'h50 + i - 3) begin errors++;
          $display("FAIL b2b%0d_head got %h want %h", i, out_data,
                   32'h50 + i - 3); end
      end
    end
    mem_write = 0;
    tick();
    reset = 0;
    tick();
    idle_inputs();
    checks++;
    if ({out_valid, level, overflow_cnt, state} !== 22'd0) begin errors++;
      $display("FAIL mid_rst got v=%0b lvl=%0d ovf=%0d st=%0d want 0",
               out_valid, level, overflow_cnt, state); end
    checks++;
    if ({out_type, out_ts, out_pc, out_addr, out_data} !== 114'd0) begin
      errors++;
      $display("FAIL mid_rst_out got t=%0d ts=%0d a=%h d=%h want 0",
               out_type, out_ts, out_addr, out_data); end
    reset = 1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_trigger();
    test_full(1'b0);
    test_full(1'b1);
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
